hdmi_in_axis: RTL

Video capture front end: samples a parallel 16-bit video bus (active, hsync, vsync, data) and emits it as an AXI4-Stream video stream (tuser = start of frame, tlast = end of line) for a VDMA write channel. It is the receive-side counterpart of the HDMI output path. The PS consumes it through the same block design that drives the HDMI transmitter. The block measures frame geometry, streams only once the geometry is stable, and absorbs short back-pressure in a small FIFO.

---
 rtl/hdmi_in_pkg.sv | 25 ++
 rtl/axis_sync_fifo.sv | 93 +++++++++
 rtl/hdmi_in_axis.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_in_pkg.sv
// Shared types and constants for the video capture front end: FSM states,
// geometry counter width and FIFO sideband bit positions.
package hdmi_in_pkg;

  localparam int GEOM_W   = 12;
  localparam int SB_W     = 2;
  localparam int SB_TLAST = 0;
  localparam int SB_TUSER = 1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    DROP    = 2'd3
  } state_t;

  function automatic logic [GEOM_W-1:0] sat_inc(input logic [GEOM_W-1:0] v);
    if (v == {GEOM_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + GEOM_W'(1);
    end
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a registered output stage; occupancy counts the
// output register, so DEPTH entries in total are held.
module axis_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  logic        pop_s;
  logic        load_out_s;
  logic        wr_acc_s;
  logic        mem_rd_s;
  logic        mem_wr_s;
  logic        bypass_s;
  logic [AW:0] occ_s;

  // Handshake decode; a pop frees a slot in the same cycle as a full write.
  always_comb begin
    occ_s      = count_r + {{AW{1'b0}}, out_valid_r};
    full       = (occ_s == DEPTH_V);
    empty      = ~out_valid_r & (count_r == {(AW+1){1'b0}});
    pop_s      = out_valid_r & rd_ready;
    wr_acc_s   = wr_en & (~full | pop_s);
    load_out_s = ~out_valid_r | pop_s;
    mem_rd_s   = load_out_s & (count_r != {(AW+1){1'b0}});
    bypass_s   = load_out_s & (count_r == {(AW+1){1'b0}}) & wr_acc_s;
    mem_wr_s   = wr_acc_s & ~bypass_s;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      if (mem_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (mem_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({mem_wr_s, mem_rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (load_out_s) begin
        if (mem_rd_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= mem_r[rd_ptr_r];
        end else if (bypass_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= wr_data;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign rd_valid = out_valid_r;
  assign rd_data  = out_data_r;

endmodule

// File: rtl/hdmi_in_axis.sv
// Video capture front end: registers a parallel video bus, measures frame
// geometry, and streams geometry-locked frames as AXI4-Stream video.
module hdmi_in_axis
  import hdmi_in_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_active,
  input  logic              vid_hsync,
  input  logic              vid_vsync,
  input  logic [DATA_W-1:0] vid_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              locked,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [11:0]       frame_width,
  output logic [11:0]       frame_height
);

  localparam int         ENTRY_W  = DATA_W + SB_W;
  localparam logic [7:0] LOCK_TGT = 8'(LOCK_FRAMES - 1);

  logic              active_r, hsync_r, vsync_r, active_d_r, vsync_d_r;
  logic [DATA_W-1:0] data_r;
  logic              vs_edge_s, act_fall_s;

  logic [GEOM_W-1:0] line_cnt_r, height_cnt_r, width_cur_r;
  logic [GEOM_W-1:0] frame_width_r, frame_height_r;
  logic              first_line_r, incons_r, geom_ok_s;

  state_t     state_r, state_nxt_s;
  logic [7:0] match_cnt_r, match_cnt_nxt_s;
  logic       locked_r;

  logic               sof_pending_r, hold_valid_r, hold_sof_r;
  logic [DATA_W-1:0]  hold_data_r;
  logic               wr_s, drop_s, overflow_r;
  logic [ENTRY_W-1:0] wr_data_s, rd_data_s;
  logic               fifo_full_s, fifo_empty_s, rd_valid_s;
  logic               unused_s;

  // Input register stage and one-cycle delayed copies for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r   <= 1'b0;
      hsync_r    <= 1'b0;
      vsync_r    <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      active_d_r <= 1'b0;
      vsync_d_r  <= 1'b0;
    end else begin
      active_r   <= vid_active;
      hsync_r    <= vid_hsync;
      vsync_r    <= vid_vsync;
      data_r     <= vid_data;
      active_d_r <= active_r;
      vsync_d_r  <= vsync_r;
    end
  end

  assign vs_edge_s  = vsync_r & ~vsync_d_r;
  assign act_fall_s = active_d_r & ~active_r;

  // Geometry measurement; the first line of a frame sets the reference width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt_r     <= {GEOM_W{1'b0}};
      height_cnt_r   <= {GEOM_W{1'b0}};
      width_cur_r    <= {GEOM_W{1'b0}};
      first_line_r   <= 1'b1;
      incons_r       <= 1'b0;
      frame_width_r  <= {GEOM_W{1'b0}};
      frame_height_r <= {GEOM_W{1'b0}};
    end else begin
      if (active_r) begin
        line_cnt_r <= active_d_r ? sat_inc(line_cnt_r) : GEOM_W'(1);
      end
      if (vs_edge_s) begin
        frame_width_r  <= width_cur_r;
        frame_height_r <= height_cnt_r;
        height_cnt_r   <= {GEOM_W{1'b0}};
        width_cur_r    <= {GEOM_W{1'b0}};
        first_line_r   <= 1'b1;
        incons_r       <= 1'b0;
      end else if (act_fall_s) begin
        height_cnt_r <= sat_inc(height_cnt_r);
        if (first_line_r) begin
          width_cur_r  <= line_cnt_r;
          first_line_r <= 1'b0;
        end else if (line_cnt_r != width_cur_r) begin
          incons_r <= 1'b1;
        end
      end
    end
  end

  assign geom_ok_s = (width_cur_r == frame_width_r) && (height_cnt_r == frame_height_r) &&
                     (width_cur_r != {GEOM_W{1'b0}}) && (height_cnt_r != {GEOM_W{1'b0}}) &&
                     !incons_r;

  // Lock FSM next-state logic; all decisions except overflow happen at a vsync edge.
  always_comb begin
    state_nxt_s     = state_r;
    match_cnt_nxt_s = match_cnt_r;
    case (state_r)
      SEARCH: begin
        if (vs_edge_s) begin
          state_nxt_s     = MEASURE;
          match_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = SEARCH;
        end
      end
      MEASURE: begin
        if (vs_edge_s && geom_ok_s && (match_cnt_r + 8'd1 >= LOCK_TGT)) begin
          state_nxt_s     = LOCKED;
          match_cnt_nxt_s = 8'd0;
        end else if (vs_edge_s && geom_ok_s) begin
          match_cnt_nxt_s = match_cnt_r + 8'd1;
        end else if (vs_edge_s) begin
          match_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = MEASURE;
        end
      end
      LOCKED: begin
        if (vs_edge_s && !geom_ok_s) begin
          state_nxt_s     = MEASURE;
          match_cnt_nxt_s = 8'd0;
        end else if (!vs_edge_s && drop_s) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      DROP: begin
        if (vs_edge_s) begin
          state_nxt_s     = geom_ok_s ? LOCKED : MEASURE;
          match_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s     = SEARCH;
        match_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Lock FSM state register and registered lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= SEARCH;
      match_cnt_r <= 8'd0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      locked_r    <= (state_nxt_s == LOCKED) || (state_nxt_s == DROP);
    end
  end

  // Tag-hold stage: the held pixel learns tlast from the following registered active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_pending_r <= 1'b0;
      hold_valid_r  <= 1'b0;
      hold_sof_r    <= 1'b0;
      hold_data_r   <= {DATA_W{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      if (vs_edge_s) begin
        sof_pending_r <= 1'b1;
      end else if (active_r) begin
        sof_pending_r <= 1'b0;
      end
      hold_valid_r <= active_r && (state_r == LOCKED);
      hold_sof_r   <= sof_pending_r;
      hold_data_r  <= data_r;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FIFO entry assembly: pixel data with {tuser, tlast} packed above it.
  always_comb begin
    wr_data_s                  = {ENTRY_W{1'b0}};
    wr_data_s[DATA_W-1:0]      = hold_data_r;
    wr_data_s[DATA_W+SB_TUSER] = hold_sof_r;
    wr_data_s[DATA_W+SB_TLAST] = ~active_r;
  end

  assign wr_s   = hold_valid_r && (state_r == LOCKED);
  assign drop_s = wr_s && fifo_full_s && !(rd_valid_s && m_axis_tready);

  axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_s),
    .wr_data  (wr_data_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .rd_valid (rd_valid_s),
    .rd_data  (rd_data_s),
    .rd_ready (m_axis_tready)
  );

  assign m_axis_tvalid = rd_valid_s;
  assign m_axis_tdata  = rd_data_s[DATA_W-1:0];
  assign m_axis_tuser  = rd_data_s[DATA_W+SB_TUSER];
  assign m_axis_tlast  = rd_data_s[DATA_W+SB_TLAST];
  assign locked        = locked_r;
  assign overflow      = overflow_r;
  assign frame_width   = frame_width_r;
  assign frame_height  = frame_height_r;

  assign unused_s = hsync_r ^ fifo_empty_s;

endmodule
